// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an 8N1 UART serialiser with its own
// per-bit cycle timer. Define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1).
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_AW      = 4
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic [7:0]         TX_DATA,
    input  logic               TX_EN,
    output logic               TX_STATUS,
    output logic               TX_BUSY,
    output logic [FIFO_AW:0]   FIFO_COUNT,
    output logic               OVERFLOW,
    output logic               UART_TX
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CTW   = FIFO_AW + 1;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_MAX    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CTW-1:0] COUNT_FULL = CTW'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]         mem [0:DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [CTW-1:0]     count_reg;
    logic               overflow_reg;
    logic [7:0]         shifter_reg;

    state_t             state_reg, state_next;
    logic [CW-1:0]      clk_cnt_reg, clk_cnt_next;
    logic [2:0]         bit_idx_reg, bit_idx_next;
    logic               tx_reg, tx_next;

    logic               wr_en;
    logic               pop;
    logic               bit_done;

    // Writes are judged on the registered count only, so a pop on the same
    // edge never makes room for a write into a full FIFO.
    assign TX_STATUS  = (count_reg != COUNT_FULL);
    assign wr_en      = TX_EN & TX_STATUS;
    assign pop        = (state_reg == IDLE) && (count_reg != '0);
    assign bit_done   = (clk_cnt_reg == CNT_MAX);

    assign TX_BUSY    = (state_reg != IDLE);
    assign FIFO_COUNT = count_reg;
    assign OVERFLOW   = overflow_reg;
    assign UART_TX    = tx_reg;

    // FIFO storage write port (no reset: plain RAM)
    always_ff @(posedge sysclk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= TX_DATA;
        end
    end

    // Registered RAM read straight into the shifter on a pop
    always_ff @(posedge sysclk) begin
        if (pop) begin
            shifter_reg <= mem[rd_ptr_reg];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + CTW'(1);
                2'b01:   count_reg <= count_reg - CTW'(1);
                default: count_reg <= count_reg;
            endcase
            if (TX_EN && !TX_STATUS) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Serialiser state register; the line is registered so it lags state by one cycle
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_idx_reg <= bit_idx_next;
            tx_reg      <= tx_next;
        end
    end

    // Next-state, bit timer and line level for the current state
    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_idx_next = bit_idx_reg;
        tx_next      = 1'b1;
        if (state_reg != IDLE) begin
            clk_cnt_next = bit_done ? '0 : clk_cnt_reg + CW'(1);
        end
        case (state_reg)
            IDLE: begin
                clk_cnt_next = '0;
                bit_idx_next = '0;
                if (pop) begin
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_next = shifter_reg[bit_idx_reg];
                if (bit_done) begin
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_next = ^shifter_reg;
                if (bit_done) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                tx_next = 1'b1;
                if (bit_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered (CLKS_PER_BIT=4, FIFO_AW=4).
// Reference model: queue of accepted bytes plus the pop edge of the frame in
// flight; the expected line level is computed from the frame timeline.
`timescale 1ns/1ps
module tb_uart_tx_buffered;
    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL    = NBITS * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          tx_status, tx_busy, ovf, uart_tx;
    logic [AW:0]   fifo_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // model state
    int         e = 0;          // index of the last clock edge
    logic [7:0] q[$];           // bytes queued, not yet popped
    bit         have_cur = 1'b0;
    int         cur_p = 0;      // edge at which the current frame was popped
    logic [7:0] cur_b = 8'h00;
    bit         m_ovf = 1'b0;

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .sysclk     (clk),
        .reset      (rst),
        .TX_DATA    (din),
        .TX_EN      (en),
        .TX_STATUS  (tx_status),
        .TX_BUSY    (tx_busy),
        .FIFO_COUNT (fifo_count),
        .OVERFLOW   (ovf),
        .UART_TX    (uart_tx)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // level of bit slot k of a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == NBITS - 1) return 1'b1;
        return ^b;
    endfunction

    function automatic logic exp_line();
        if (have_cur && e >= cur_p + 1 && e <= cur_p + FL)
            return frame_bit(cur_b, (e - cur_p - 1) / CPB);
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return have_cur && e >= cur_p && e <= cur_p + FL - 1;
    endfunction

    // advance one clock edge and apply the same edge to the model
    task automatic tick();
        int pre_cnt;
        bit pre_idle;
        @(posedge clk);
        e = e + 1;
        if (rst) begin
            q.delete();
            have_cur = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            pre_cnt  = q.size();
            pre_idle = !have_cur || (e >= cur_p + FL + 1);
            if (en) begin
                if (pre_cnt < DEPTH) q.push_back(din);
                else m_ovf = 1'b1;
            end
            if (pre_idle && pre_cnt != 0) begin
                cur_b    = q.pop_front();
                cur_p    = e;
                have_cur = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        en  = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3);
        tests_run += 5;
        if (uart_tx !== 1'b1) begin tests_failed++; $display("FAIL reset_uart_tx got %b exp 1", uart_tx); end
        if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
        if (tx_status !== 1'b1) begin tests_failed++; $display("FAIL reset_status got %b exp 1", tx_status); end
        if (fifo_count !== '0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b exp 0", ovf); end
        $display("[TB] reset checked");
    endtask

    task automatic test_single_byte();
        int n_edge;
        int fall = -1;
        int busy_cycles = 0;
        din = 8'h55; en = 1'b1; tick(); en = 1'b0;
        n_edge = e;
        for (int i = 0; i < FL + 20; i++) begin
            tick();
            tests_run += 2;
            if (uart_tx !== exp_line()) begin tests_failed++; $display("FAIL single_line e=%0d got %b exp %b", e, uart_tx, exp_line()); end
            if (tx_busy !== exp_busy()) begin tests_failed++; $display("FAIL single_busy e=%0d got %b exp %b", e, tx_busy, exp_busy()); end
            if (uart_tx === 1'b0 && fall < 0) fall = e;
            if (tx_busy === 1'b1) busy_cycles++;
        end
        tests_run += 2;
        if (fall !== n_edge + 2) begin tests_failed++; $display("FAIL single_latency fall_edge=%0d exp %0d", fall, n_edge + 2); end
        if (busy_cycles !== FL) begin tests_failed++; $display("FAIL single_busy_len got %0d exp %0d", busy_cycles, FL); end
        $display("[TB] byte 0x55 sent, fall at edge %0d, busy %0d cycles", fall, busy_cycles);
    endtask

    task automatic test_fill_overflow();
        int frames = 0;
        logic busy_prev;
        // 17 consecutive writes into an idle transmitter: none blocked
        do_reset(1);
        for (int i = 0; i < 17; i++) begin
            din = 8'(i); en = 1'b1; tick();
            tests_run += 2;
            if (fifo_count !== q.size()) begin tests_failed++; $display("FAIL fill_count i=%0d got %0d exp %0d", i, fifo_count, q.size()); end
            if (tx_status !== (q.size() != DEPTH)) begin tests_failed++; $display("FAIL fill_status i=%0d got %b", i, tx_status); end
            if (i == 15) begin
                tests_run++;
                if (fifo_count !== 15) begin tests_failed++; $display("FAIL fill_peak got %0d exp 15", fifo_count); end
            end
        end
        en = 1'b0;
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL fill_no_overflow got %b exp 0", ovf); end
        $display("[TB] 17 bytes written at full rate, count %0d", fifo_count);

        // fill while a frame is in flight, 17th write must overflow
        do_reset(1);
        din = 8'hAA; en = 1'b1; tick(); en = 1'b0;
        tick(); tick();
        for (int i = 0; i < 17; i++) begin
            din = 8'($urandom); en = 1'b1; tick();
            tests_run += 3;
            if (fifo_count !== q.size()) begin tests_failed++; $display("FAIL ovf_count i=%0d got %0d exp %0d", i, fifo_count, q.size()); end
            if (tx_status !== (q.size() != DEPTH)) begin tests_failed++; $display("FAIL ovf_status i=%0d got %b", i, tx_status); end
            if (ovf !== m_ovf) begin tests_failed++; $display("FAIL ovf_flag i=%0d got %b exp %b", i, ovf, m_ovf); end
            if (i == 15) begin
                tests_run++;
                if (tx_status !== 1'b0) begin tests_failed++; $display("FAIL full_status got %b exp 0", tx_status); end
            end
        end
        en = 1'b0;
        tests_run++;
        if (ovf !== 1'b1) begin tests_failed++; $display("FAIL overflow_set got %b exp 1", ovf); end
        // drain: every accepted frame in order with a one-cycle gap
        busy_prev = tx_busy;
        for (int i = 0; i < 17 * (FL + 1) + 10; i++) begin
            tick();
            tests_run += 3;
            if (uart_tx !== exp_line()) begin tests_failed++; $display("FAIL drain_line e=%0d got %b exp %b", e, uart_tx, exp_line()); end
            if (tx_busy !== exp_busy()) begin tests_failed++; $display("FAIL drain_busy e=%0d got %b exp %b", e, tx_busy, exp_busy()); end
            if (fifo_count !== q.size()) begin tests_failed++; $display("FAIL drain_count e=%0d got %0d exp %0d", e, fifo_count, q.size()); end
            if (tx_busy === 1'b1 && busy_prev !== 1'b1) frames++;
            busy_prev = tx_busy;
        end
        tests_run++;
        if (frames !== 16) begin tests_failed++; $display("FAIL drain_frames got %0d exp 16", frames); end
        $display("[TB] overflow scenario drained, %0d further frames", frames);
    endtask

    task automatic test_write_full_pop();
        int guard = 0;
        do_reset(1);
        din = 8'h11; en = 1'b1; tick(); en = 1'b0;
        tick(); tick();
        for (int i = 0; i < 16; i++) begin
            din = 8'($urandom); en = 1'b1; tick();
        end
        en = 1'b0;
        while (e < cur_p + FL && guard < 200) begin
            tick();
            guard++;
        end
        din = 8'hEE; en = 1'b1; tick(); en = 1'b0;
        tests_run += 4;
        if (fifo_count !== 15) begin tests_failed++; $display("FAIL fullpop_count got %0d exp 15", fifo_count); end
        if (ovf !== 1'b1) begin tests_failed++; $display("FAIL fullpop_overflow got %b exp 1", ovf); end
        if (tx_busy !== 1'b1) begin tests_failed++; $display("FAIL fullpop_busy got %b exp 1", tx_busy); end
        if (fifo_count !== q.size()) begin tests_failed++; $display("FAIL fullpop_model got %0d exp %0d", fifo_count, q.size()); end
        $display("[TB] write at full during pop rejected, count %0d", fifo_count);
    endtask

    task automatic test_reset_mid_frame();
        int guard = 0;
        do_reset(1);
        din = 8'hA5; en = 1'b1; tick();
        din = 8'h3C; tick();
        din = 8'hC3; tick();
        en = 1'b0;
        while (e < cur_p + 17 && guard < 100) begin
            tick();
            guard++;
        end
        tests_run += 2;
        if (fifo_count !== 2) begin tests_failed++; $display("FAIL mid_pre_count got %0d exp 2", fifo_count); end
        if (uart_tx !== exp_line()) begin tests_failed++; $display("FAIL mid_pre_line got %b exp %b", uart_tx, exp_line()); end
        rst = 1'b1; tick(); rst = 1'b0;
        tests_run += 3;
        if (uart_tx !== 1'b1) begin tests_failed++; $display("FAIL mid_uart_tx got %b exp 1", uart_tx); end
        if (fifo_count !== 0) begin tests_failed++; $display("FAIL mid_count got %0d exp 0", fifo_count); end
        if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy got %b exp 0", tx_busy); end
        for (int i = 0; i < 100; i++) begin
            tick();
            tests_run += 2;
            if (uart_tx !== 1'b1) begin tests_failed++; $display("FAIL mid_quiet_line e=%0d got %b exp 1", e, uart_tx); end
            if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL mid_quiet_busy e=%0d got %b exp 0", e, tx_busy); end
        end
        $display("[TB] reset during frame 0xA5 aborted transmission");
    endtask

    task automatic test_random();
        int writes = 0;
        do_reset(1);
        for (int i = 0; i < 2000 + 17 * (FL + 1); i++) begin
            if (i < 2000) begin
                en  = ($urandom_range(0, 99) < ((i < 1000) ? 3 : 40));
                din = 8'($urandom);
                if (en) writes++;
            end else begin
                en = 1'b0;
            end
            tick();
            tests_run += 5;
            if (uart_tx !== exp_line()) begin tests_failed++; $display("FAIL rand_line e=%0d got %b exp %b", e, uart_tx, exp_line()); end
            if (tx_busy !== exp_busy()) begin tests_failed++; $display("FAIL rand_busy e=%0d got %b exp %b", e, tx_busy, exp_busy()); end
            if (fifo_count !== q.size()) begin tests_failed++; $display("FAIL rand_count e=%0d got %0d exp %0d", e, fifo_count, q.size()); end
            if (tx_status !== (q.size() != DEPTH)) begin tests_failed++; $display("FAIL rand_status e=%0d got %b", e, tx_status); end
            if (ovf !== m_ovf) begin tests_failed++; $display("FAIL rand_overflow e=%0d got %b exp %b", e, ovf, m_ovf); end
        end
        $display("[TB] random traffic: %0d write strobes, overflow %b", writes, ovf);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals [2];
        logic       pars [2];
        logic       par_seen;
        logic       stop_seen;
        int         busy_cycles;
        vals[0] = 8'h07; pars[0] = 1'b1;
        vals[1] = 8'h03; pars[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            do_reset(1);
            par_seen = 1'bx; stop_seen = 1'bx; busy_cycles = 0;
            din = vals[t]; en = 1'b1; tick(); en = 1'b0;
            for (int i = 0; i < FL + 10; i++) begin
                tick();
                if (have_cur && e == cur_p + 1 + 9 * CPB) par_seen = uart_tx;
                if (have_cur && e == cur_p + 1 + 10 * CPB) stop_seen = uart_tx;
                if (tx_busy === 1'b1) busy_cycles++;
            end
            tests_run += 3;
            if (par_seen !== pars[t]) begin tests_failed++; $display("FAIL parity_bit data=%h got %b exp %b", vals[t], par_seen, pars[t]); end
            if (stop_seen !== 1'b1) begin tests_failed++; $display("FAIL parity_stop data=%h got %b exp 1", vals[t], stop_seen); end
            if (busy_cycles !== 44) begin tests_failed++; $display("FAIL parity_len data=%h got %0d exp 44", vals[t], busy_cycles); end
            $display("[TB] parity frame 0x%h: parity %b, stop %b", vals[t], par_seen, stop_seen);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_write_full_pop();
        test_reset_mid_frame();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
